// File: rtl/pi_control_div_seq.sv
// Sequential signed restoring divider: signed dividend / signed divisor, one quotient
// bit per clock, saturated quotient and dividend-signed remainder, ap_* handshake.
module pi_control_div_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 17,
  parameter int QUOTIENT_WIDTH = 16
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             ap_start,
  output logic                             ap_ready,
  output logic                             ap_idle,
  output logic                             ap_done,
  input  logic signed [DIVIDEND_WIDTH-1:0] din0,
  input  logic signed [DIVISOR_WIDTH-1:0]  din1,
  output logic signed [QUOTIENT_WIDTH-1:0] quot,
  output logic signed [DIVISOR_WIDTH-1:0]  rem,
  output logic                             ovf,
  output logic                             div_by_zero
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int RW = DIVISOR_WIDTH + 1;
  localparam int CW = $clog2(DIVIDEND_WIDTH);

  localparam logic [DW-1:0] L_NEG_LIMIT = {{(DW-1){1'b0}}, 1'b1} << (QW-1);
  localparam logic [DW-1:0] L_POS_LIMIT = L_NEG_LIMIT - 1'b1;
  localparam logic [QW-1:0] L_QMAX      = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] L_QMIN      = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [DW-1:0]   r_dvdMag;
  logic [VW-1:0]   r_dvsMag;
  logic [RW-1:0]   r_pr;
  logic [CW-1:0]   r_cnt;
  logic            r_dvdNeg;
  logic            r_quoNeg;
  logic            r_dvsZero;

  logic            w_accept;
  logic [RW-1:0]   w_shift;
  logic [RW-1:0]   w_sub;
  logic            w_ge;
  logic [RW-1:0]   w_prNext;
  logic [QW-1:0]   w_qLow;
  logic [QW-1:0]   w_qSigned;
  logic [VW-1:0]   w_remMag;
  logic [VW-1:0]   w_remSigned;
  logic            w_sat;

  assign w_accept = ap_ready & ap_start;

  // The comparison sees every partial-remainder bit; the subtraction only needs the
  // low bits because a successful subtract always leaves less than the divisor.
  assign w_shift  = {r_pr[RW-2:0], r_dvdMag[DW-1]};
  assign w_ge     = ({r_pr, r_dvdMag[DW-1]} >= {2'b00, r_dvsMag});
  assign w_sub    = w_shift - {1'b0, r_dvsMag};
  assign w_prNext = w_ge ? w_sub : w_shift;

  assign w_qLow      = r_dvdMag[QW-1:0];
  assign w_qSigned   = r_quoNeg ? -w_qLow : w_qLow;
  assign w_remMag    = r_pr[VW-1:0];
  assign w_remSigned = r_dvdNeg ? -w_remMag : w_remMag;
  assign w_sat       = r_quoNeg ? (r_dvdMag > L_NEG_LIMIT) : (r_dvdMag > L_POS_LIMIT);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (ap_start) w_nextState = S_CALC;
      S_CALC: if (r_cnt == '0) w_nextState = S_FIX;
      S_FIX:  w_nextState = S_DONE;
      S_DONE: w_nextState = ap_start ? S_CALC : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ap_ready = 1'b1;
        ap_idle  = 1'b1;
      end
      S_DONE: begin
        ap_ready = 1'b1;
        ap_done  = 1'b1;
      end
      default: ;
    endcase
  end

  // Quotient bits shift into the vacated LSBs of the dividend magnitude register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_dvdMag    <= '0;
      r_dvsMag    <= '0;
      r_pr        <= '0;
      r_cnt       <= '0;
      r_dvdNeg    <= 1'b0;
      r_quoNeg    <= 1'b0;
      r_dvsZero   <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_dvdMag  <= din0[DW-1] ? -din0 : din0;
      r_dvsMag  <= din1[VW-1] ? -din1 : din1;
      r_pr      <= '0;
      r_cnt     <= CW'(DW - 1);
      r_dvdNeg  <= din0[DW-1];
      r_quoNeg  <= din0[DW-1] ^ din1[VW-1];
      r_dvsZero <= (din1 == '0);
    end else if (r_state == S_CALC) begin
      r_pr     <= w_prNext;
      r_dvdMag <= {r_dvdMag[DW-2:0], w_ge};
      r_cnt    <= r_cnt - 1'b1;
    end else if (r_state == S_FIX) begin
      if (r_dvsZero) begin
        quot        <= r_dvdNeg ? L_QMIN : L_QMAX;
        rem         <= '0;
        ovf         <= 1'b0;
        div_by_zero <= 1'b1;
      end else if (w_sat) begin
        quot        <= r_quoNeg ? L_QMIN : L_QMAX;
        rem         <= '0;
        ovf         <= 1'b1;
        div_by_zero <= 1'b0;
      end else begin
        quot        <= w_qSigned;
        rem         <= w_remSigned;
        ovf         <= 1'b0;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pi_control_div_seq.sv
// Scoreboard bench for pi_control_div_seq: integer-arithmetic reference model,
// directed corner cases, randomized operands, handshake/latency/reset checks.
module tb_pi_control_div_seq;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic               ap_start = 1'b0;
  logic               ap_ready;
  logic               ap_idle;
  logic               ap_done;
  logic signed [31:0] din0 = '0;
  logic signed [16:0] din1 = '0;
  logic signed [15:0] quot;
  logic signed [16:0] rem;
  logic               ovf;
  logic               div_by_zero;

  typedef struct {
    logic signed [15:0] quot;
    logic signed [16:0] rem;
    logic               ovf;
    logic               dbz;
  } exp_t;

  exp_t   expQ[$];
  longint acceptQ[$];
  longint cycleCount = 0;
  int     nVectors = 0;
  int     nMiscompares = 0;

  pi_control_div_seq dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_idle(ap_idle),
    .ap_done(ap_done),
    .din0(din0),
    .din1(din1),
    .quot(quot),
    .rem(rem),
    .ovf(ovf),
    .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Truncating integer division with the remainder taking the dividend's sign.
  function automatic exp_t refDivide(input longint a, input longint b);
    exp_t   e;
    longint q;
    longint r;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.rem = '0;
    if (b == 0) begin
      e.dbz  = 1'b1;
      e.quot = (a < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 32767) begin
        e.quot = 16'h7FFF;
        e.ovf  = 1'b1;
      end else if (q < -32768) begin
        e.quot = 16'h8000;
        e.ovf  = 1'b1;
      end else begin
        e.quot = 16'(q);
        e.rem  = 17'(r);
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  initial begin
    exp_t   e;
    longint t;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst && ap_done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = expQ.pop_front();
          t = acceptQ.pop_front();
          checkOutput("quot", quot, e.quot);
          checkOutput("rem", rem, e.rem);
          checkOutput("ovf", ovf, e.ovf);
          checkOutput("div_by_zero", div_by_zero, e.dbz);
          checkOutput("latency", cycleCount - t, 34);
        end
      end
    end
  end

  task automatic applyStimulus(input logic signed [31:0] a, input logic signed [16:0] b,
                               input int gap);
    int w;
    repeat (gap) @(negedge ap_clk);
    w = 0;
    while (!ap_ready && w < 50) begin
      @(negedge ap_clk);
      w++;
    end
    if (!ap_ready) checkOutput("ready_timeout", 0, 1);
    din0     = a;
    din1     = b;
    ap_start = 1'b1;
    expQ.push_back(refDivide(longint'(a), longint'(b)));
    acceptQ.push_back(cycleCount);
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    din0     = $urandom;
    din1     = 17'($urandom);
  endtask

  task automatic waitDone(output int busyViol);
    bit seen;
    busyViol = 0;
    seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge ap_clk);
      if (ap_done) seen = 1'b1;
      else if (ap_ready || ap_idle) busyViol++;
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic runOp(input logic signed [31:0] a, input logic signed [16:0] b, input int gap);
    int v;
    applyStimulus(a, b, gap);
    waitDone(v);
    checkOutput("busy_handshake", v, 0);
  endtask

  initial begin
    int                 v;
    int                 doneCount;
    logic signed [31:0] ra;
    logic signed [16:0] rb;

    repeat (3) @(negedge ap_clk);
    checkOutput("rst_quot", quot, 0);
    checkOutput("rst_rem", rem, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_dbz", div_by_zero, 0);
    checkOutput("rst_ready", ap_ready, 1);
    checkOutput("rst_idle", ap_idle, 1);
    checkOutput("rst_done", ap_done, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    runOp(32'sd1000, 17'sd7, 0);
    @(negedge ap_clk);
    checkOutput("done_pulse_width", ap_done, 0);
    checkOutput("idle_after_done", ap_idle, 1);
    checkOutput("quot_held", quot, 142);

    runOp(-32'sd1000, 17'sd7, 1);
    runOp(32'sd1000, -17'sd7, 2);
    runOp(32'sh7FFF_FFFF, 17'sd3, 1);
    runOp(32'sh8000_0000, 17'sh1_0000, 1);
    runOp(32'sh8000_0000, 17'sd65535, 1);
    runOp(32'sd1234, 17'sd0, 1);
    runOp(-32'sd5, 17'sd0, 1);

    // Start pulses and new operands during CALC must not disturb the running division.
    applyStimulus(-32'sd777777, 17'sd321, 1);
    repeat (5) @(negedge ap_clk);
    ap_start = 1'b1;
    din0     = 32'sd99;
    din1     = 17'sd1;
    repeat (3) @(negedge ap_clk);
    ap_start = 1'b0;
    waitDone(v);
    checkOutput("busy_ignore_start", v, 0);

    // Abort mid-CALC; outputs must clear before any clock edge.
    applyStimulus(32'sd5000, 17'sd3, 1);
    repeat (10) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    checkOutput("abort_quot", quot, 0);
    checkOutput("abort_rem", rem, 0);
    checkOutput("abort_ovf", ovf, 0);
    checkOutput("abort_dbz", div_by_zero, 0);
    checkOutput("abort_idle", ap_idle, 1);
    checkOutput("abort_ready", ap_ready, 1);
    checkOutput("abort_done", ap_done, 0);
    expQ.delete();
    acceptQ.delete();
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    doneCount = 0;
    repeat (40) begin
      @(negedge ap_clk);
      if (ap_done) doneCount++;
    end
    checkOutput("abort_no_done", doneCount, 0);

    runOp(32'sd1000, 17'sd7, 0);
    applyStimulus(32'sd4242, -17'sd13, 0);
    @(negedge ap_clk);
    checkOutput("b2b_no_idle", ap_idle, 0);
    waitDone(v);
    checkOutput("b2b_busy", v, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: ra = $urandom;
        1: ra = 32'($urandom_range(0, 200000));
        default: ra = 32'($urandom_range(0, 40000000));
      endcase
      if ($urandom_range(0, 1) == 1) ra = -ra;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 17'sh1_0000;
        2, 3: rb = 17'($urandom_range(1, 20));
        default: rb = 17'($urandom_range(1, 65535));
      endcase
      if ($urandom_range(0, 1) == 1) rb = -rb;
      runOp(ra, rb, $urandom_range(0, 2));
    end

    repeat (5) @(negedge ap_clk);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #1000000;
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
